// File: rtl/dvi_scanline_doubler_pkg.sv
// Shared constants and colour helpers for the scanline doubler.
package dvi_scanline_pkg;

  // Default geometry: 320x240 source doubled to 640x480.
  localparam int IN_W_DEF  = 320;
  localparam int OUT_H_DEF = 480;

  // RGB565 field offsets within a 16-bit pixel {r5, g6, b5}.
  localparam int R_LSB = 11;
  localparam int G_LSB = 5;
  localparam int B_LSB = 0;

  // Widen a 5-bit channel to 8 bits by replicating its top bits into the LSBs.
  function automatic logic [7:0] expand5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  // Widen a 6-bit channel to 8 bits by replicating its top bits into the LSBs.
  function automatic logic [7:0] expand6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

endpackage

// File: rtl/dvi_scanline_doubler_if.sv
// Pixel-in stream, encoder handshake and status signals of the doubler.
interface dvi_scanline_doubler_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic        rgb_rdy;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        frame_start;
  logic        underrun;
  logic        clr_underrun;

  // System side (pixel source plus encoder) drives the stream and rgb_rdy.
  modport master (
    output in_data, in_valid, in_sof, rgb_rdy, clr_underrun,
    input  in_ready, r, g, b, frame_start, underrun
  );

  // The doubler itself.
  modport slave (
    input  in_data, in_valid, in_sof, rgb_rdy, clr_underrun,
    output in_ready, r, g, b, frame_start, underrun
  );
endinterface

// File: rtl/dvi_scanline_doubler_line_ram.sv
// Two-bank line buffer: simple dual-port RAM, synchronous read with enable.
// The bank select is the address MSB, so the depth is rounded to a power of two.
module dvi_line_ram #(
  parameter int AW = 9
) (
  input  logic          clk_pix,
  input  logic          i_we,
  input  logic [AW:0]   i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW:0]   i_raddr,
  output logic [15:0]   o_rdata
);
  localparam int DEPTH = 2 << AW;

  logic [15:0] r_mem [0:DEPTH-1];
  logic [15:0] r_q;

  // Write port and registered read port; output holds when read is idle.
  always_ff @(posedge clk_pix) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/dvi_scanline_doubler.sv
// 2x2 scanline doubler: buffers RGB565 lines in a ping-pong pair and replays
// each pixel twice and each line twice as RGB888 under the encoder handshake.
module dvi_scanline_doubler
  import dvi_scanline_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_H = OUT_H_DEF,
  parameter int AW    = $clog2(IN_W)
) (
  input  logic                  clk_pix,
  input  logic                  rst_pix,
  dvi_scanline_doubler_if.slave pix_if
);
  localparam int RW = $clog2(OUT_H);
  localparam logic [AW-1:0] COL_LAST = AW'(IN_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);

  logic [1:0]    r_full, w_full_next, w_full_set, w_full_clr;
  logic          r_wr_bank, w_wr_bank_next;
  logic [AW-1:0] r_wr_col, w_wr_col_next, w_wr_addr_col;
  logic          r_rd_bank, w_rd_bank_next;
  logic [RW-1:0] r_row, w_row_next;
  logic [AW-1:0] r_col, w_col_next;
  logic          r_half, w_half_next;
  logic          r_line_ok, w_line_ok_next;
  logic          r_underrun, w_underrun_set, w_underrun_next;
  logic          r_frame_start, w_frame_start_next;
  logic          w_accept, w_row_end;
  logic [15:0]   w_pix;

  assign w_accept  = pix_if.in_valid && pix_if.in_ready;
  assign w_row_end = r_half && (r_col == COL_LAST);

  // Write side: column counter, sof resync and bank completion.
  always_comb begin
    w_wr_col_next  = r_wr_col;
    w_wr_bank_next = r_wr_bank;
    w_full_set     = 2'b00;
    w_wr_addr_col  = pix_if.in_sof ? '0 : r_wr_col;
    if (w_accept) begin
      if (pix_if.in_sof) begin
        w_wr_col_next = AW'(1);
      end else if (r_wr_col == COL_LAST) begin
        w_wr_col_next         = '0;
        w_wr_bank_next        = ~r_wr_bank;
        w_full_set[r_wr_bank] = 1'b1;
      end else begin
        w_wr_col_next = r_wr_col + AW'(1);
      end
    end
  end

  // Read side: output position, row-pair decisions, underrun and frame pulse.
  always_comb begin
    w_half_next        = r_half;
    w_col_next         = r_col;
    w_row_next         = r_row;
    w_rd_bank_next     = r_rd_bank;
    w_line_ok_next     = r_line_ok;
    w_full_clr         = 2'b00;
    w_underrun_set     = 1'b0;
    w_frame_start_next = 1'b0;
    if (pix_if.rgb_rdy) begin
      w_half_next = ~r_half;
      if (r_half) begin
        if (w_row_end) begin
          w_col_next         = '0;
          w_row_next         = (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
          w_frame_start_next = (r_row == ROW_LAST);
          // Leaving an odd row means entering an even one: retire the shown
          // line if it was valid, then pick up whatever bank is ready now.
          if (r_row[0]) begin
            if (r_line_ok) begin
              w_full_clr[r_rd_bank] = 1'b1;
              w_rd_bank_next        = ~r_rd_bank;
            end
            w_line_ok_next = r_full[w_rd_bank_next];
            w_underrun_set = !r_full[w_rd_bank_next];
          end
        end else begin
          w_col_next = r_col + AW'(1);
        end
      end
    end
    w_full_next     = (r_full & ~w_full_clr) | w_full_set;
    w_underrun_next = w_underrun_set ? 1'b1 :
                      (pix_if.clr_underrun ? 1'b0 : r_underrun);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_full        <= 2'b00;
      r_wr_bank     <= 1'b0;
      r_wr_col      <= '0;
      r_rd_bank     <= 1'b0;
      r_row         <= '0;
      r_col         <= '0;
      r_half        <= 1'b0;
      r_line_ok     <= 1'b0;
      r_underrun    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_full        <= w_full_next;
      r_wr_bank     <= w_wr_bank_next;
      r_wr_col      <= w_wr_col_next;
      r_rd_bank     <= w_rd_bank_next;
      r_row         <= w_row_next;
      r_col         <= w_col_next;
      r_half        <= w_half_next;
      r_line_ok     <= w_line_ok_next;
      r_underrun    <= w_underrun_next;
      r_frame_start <= w_frame_start_next;
    end
  end

  dvi_line_ram #(.AW(AW)) u_line_ram (
    .clk_pix (clk_pix),
    .i_we    (w_accept),
    .i_waddr ({r_wr_bank, w_wr_addr_col}),
    .i_wdata (pix_if.in_data),
    .i_re    (pix_if.rgb_rdy),
    .i_raddr ({w_rd_bank_next, w_col_next}),
    .o_rdata (w_pix)
  );

  assign pix_if.in_ready    = !r_full[r_wr_bank];
  assign pix_if.underrun    = r_underrun;
  assign pix_if.frame_start = r_frame_start;
  assign pix_if.r = r_line_ok ? expand5(w_pix[R_LSB +: 5]) : 8'h00;
  assign pix_if.g = r_line_ok ? expand6(w_pix[G_LSB +: 6]) : 8'h00;
  assign pix_if.b = r_line_ok ? expand5(w_pix[B_LSB +: 5]) : 8'h00;
endmodule

// File: tb/tb_dvi_scanline_doubler.sv
// Directed bench for the scanline doubler on a reduced 16-pixel x 8-row geometry.
module tb_dvi_scanline_doubler;
  localparam int W = 16;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic s_rdy_before, s_rdy_after, s_fs_after;
  logic [15:0] lines [4][W];

  dvi_scanline_doubler_if bus();

  dvi_scanline_doubler #(.IN_W(W), .OUT_H(H)) dut (
    .clk_pix (clk),
    .rst_pix (rst),
    .pix_if  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input logic [15:0] d);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = d[15:11];
    g6 = d[10:5];
    b5 = d[4:0];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input bit sof);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    check_val("push_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.in_data  = d;
    bus.in_sof   = sof;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic push_line(input int sel);
    for (int c = 0; c < W; c++) push(lines[sel][c], 1'b0);
  endtask

  // One rgb_rdy pulse followed by an idle cycle.
  task automatic pulse();
    s_rdy_before = bus.in_ready;
    bus.rgb_rdy = 1'b1;
    tick();
    bus.rgb_rdy = 1'b0;
    s_rdy_after = bus.in_ready;
    s_fs_after  = bus.frame_start;
    tick();
  endtask

  task automatic consume_span(input int sel, input bit black, input int start, input int n, input string tag);
    logic [23:0] exp;
    for (int i = start; i < start + n; i++) begin
      exp = black ? 24'h0 : exp_rgb(lines[sel][i/2]);
      check_val($sformatf("%s_c%0d_h%0d", tag, i/2, i%2), {8'h0, bus.r, bus.g, bus.b}, {8'h0, exp});
      pulse();
    end
  endtask

  task automatic consume_row(input int sel, input bit black, input string tag);
    consume_span(sel, black, 0, 2*W, tag);
  endtask

  initial begin
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    bus.rgb_rdy = 1'b0; bus.clr_underrun = 1'b0;
    for (int c = 0; c < W; c++) begin
      lines[0][c] = 16'(c);
      lines[1][c] = (c == 0) ? 16'hF800 : (c == 1) ? 16'h07E0 : (c == 2) ? 16'h0841 : 16'hFFFF;
      lines[2][c] = (c == 0) ? 16'hF81F : 16'(c * 16'h0800);
      lines[3][c] = 16'h5555 ^ 16'(c);
    end

    #1 rst = 1'b1;
    repeat (3) tick();
    check_val("rst_rgb", {8'h0, bus.r, bus.g, bus.b}, 32'h0);
    check_val("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check_val("rst_underrun", {31'b0, bus.underrun}, 32'd0);
    check_val("rst_frame_start", {31'b0, bus.frame_start}, 32'd0);
    #2 rst = 1'b0;
    tick();

    // Fill both banks with no consumption: backpressure after the second line.
    push_line(0);
    check_val("ready_after_line0", {31'b0, bus.in_ready}, 32'd1);
    push_line(1);
    check_val("ready_after_line1", {31'b0, bus.in_ready}, 32'd0);

    // First row pair after reset is black and not flagged.
    consume_row(0, 1'b1, "f0_r0");
    check_val("underrun_r0", {31'b0, bus.underrun}, 32'd0);
    consume_row(0, 1'b1, "f0_r1");
    check_val("underrun_r1", {31'b0, bus.underrun}, 32'd0);
    check_val("fs_r1", {31'b0, s_fs_after}, 32'd0);

    // Line replay of index data in rows 2 and 3; bank 0 freed after row 3.
    consume_row(0, 1'b0, "r2");
    check_val("ready_mid_pair", {31'b0, bus.in_ready}, 32'd0);
    consume_row(0, 1'b0, "r3");
    check_val("ready_before_free", {31'b0, s_rdy_before}, 32'd0);
    check_val("ready_after_free", {31'b0, s_rdy_after}, 32'd1);

    // Colour expansion on row 4 with hand-computed values.
    check_val("col_F800", {8'h0, bus.r, bus.g, bus.b}, 32'h00FF0000);
    pulse(); pulse();
    check_val("col_07E0", {8'h0, bus.r, bus.g, bus.b}, 32'h0000FF00);
    pulse(); pulse();
    check_val("col_0841", {8'h0, bus.r, bus.g, bus.b}, 32'h00080808);
    pulse(); pulse();
    consume_span(1, 1'b0, 6, 2*W-6, "r4");
    consume_row(1, 1'b0, "r5");
    check_val("underrun_set_r6", {31'b0, bus.underrun}, 32'd1);
    check_val("fs_r5", {31'b0, s_fs_after}, 32'd0);

    // Row 6 starved; a line arriving mid-row (with sof resync) waits for row 0.
    consume_span(0, 1'b1, 0, W, "r6a");
    for (int k = 0; k < 5; k++) push(16'hAAAA, 1'b0);
    push(lines[2][0], 1'b1);
    for (int c = 1; c < W; c++) push(lines[2][c], 1'b0);
    consume_span(0, 1'b1, W, W, "r6b");
    check_val("underrun_sticky", {31'b0, bus.underrun}, 32'd1);
    consume_span(0, 1'b1, 0, W, "r7a");
    bus.clr_underrun = 1'b1;
    tick();
    bus.clr_underrun = 1'b0;
    check_val("underrun_cleared", {31'b0, bus.underrun}, 32'd0);
    consume_span(0, 1'b1, W, W, "r7b");
    check_val("fs_pulse", {31'b0, s_fs_after}, 32'd1);
    check_val("fs_one_cycle", {31'b0, bus.frame_start}, 32'd0);
    check_val("underrun_after_wrap", {31'b0, bus.underrun}, 32'd0);

    // Frame 2 row 0 shows the resynced line; a fourth line fills bank 1.
    consume_span(2, 1'b0, 0, W, "f2_r0a");
    push_line(3);
    check_val("ready_both_full", {31'b0, bus.in_ready}, 32'd0);
    consume_span(2, 1'b0, W, W, "f2_r0b");
    consume_span(2, 1'b0, 0, 7, "f2_r1");
    check_val("pre_reset_pixel", {8'h0, bus.r, bus.g, bus.b}, {8'h0, exp_rgb(lines[2][3])});

    // Asynchronous reset mid-frame.
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_rgb", {8'h0, bus.r, bus.g, bus.b}, 32'h0);
    check_val("async_rst_ready", {31'b0, bus.in_ready}, 32'd1);
    check_val("async_rst_underrun", {31'b0, bus.underrun}, 32'd0);
    #3 rst = 1'b0;
    tick();
    consume_row(0, 1'b1, "post_rst_r0");
    check_val("post_rst_underrun_r0", {31'b0, bus.underrun}, 32'd0);
    consume_row(0, 1'b1, "post_rst_r1");
    check_val("post_rst_underrun_r2", {31'b0, bus.underrun}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dvi_scanline_doubler.md
Name: dvi_scanline_doubler

Overview:
- Pixel source that sits directly upstream of the DVI encoder in the clk_pix domain and drives its r/g/b inputs under its rgb_rdy handshake.
- Accepts a 320x240 RGB565 pixel stream from a system master through a valid/ready port and stores it in a ping-pong pair of line buffers.
- Emits each pixel twice horizontally and each line twice vertically, giving a 640x480 RGB888 frame.
- Runs the encoder in black and flags an underrun when a line is missing.

Parameters:
- IN_W, 320, input pixels per line; each output row is 2*IN_W pixels.
- OUT_H, 480, output rows per frame; each input line covers 2 output rows.
- AW, $clog2(IN_W), line-buffer column address width.

Ports:
- clk_pix  in  1  pixel clock; the only clock.
- rst_pix  in  1  asynchronous reset, active-high.
- in_data  in  16  RGB565 pixel, {r5,g6,b5}.
- in_valid  in  1  in_data valid.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- in_sof  in  1  qualifies the accepted pixel as column 0 of a line (resync).
- rgb_rdy  in  1  consumer takes the current r/g/b this cycle; never high on two consecutive cycles.
- r  out  8  red.
- g  out  8  green.
- b  out  8  blue.
- frame_start  out  1  one-cycle pulse marking the start of a frame.
- underrun  out  1  sticky, set when an output row had no line available.
- clr_underrun  in  1  clears underrun.

Behaviour:
- Reset values:
  - r=g=b=0, in_ready=1, underrun=0, frame_start=0.
  - Both bank-full flags 0, wr_bank=rd_bank=0, wr_col=0.
  - Output position row=0, col=0, half=0; line_ok=0.
- Write side:
  - On accept, store in_data at [wr_bank][wr_col] and increment wr_col.
  - Accept with in_sof=1 writes at column 0 and sets wr_col=1; any partial line is discarded.
  - At wr_col==IN_W-1 accept: set full[wr_bank], toggle wr_bank, set wr_col=0.
  - in_ready = !full[wr_bank] (combinational from registered flags).
- Output position advances only on rgb_rdy cycles:
  - half toggles on every rgb_rdy; col increments when half goes 1->0.
  - At col==IN_W-1, half=1, row increments; at row OUT_H-1 it wraps to 0.
- Row decision, made in the rgb_rdy cycle that consumes the last pixel of the previous row:
  - Entering an even row: line_ok <= full[rd_bank].
  - Entering an odd row: line_ok is unchanged.
  - Leaving an odd row with line_ok=1: clear full[rd_bank] and toggle rd_bank.
  - Leaving an odd row with line_ok=0: rd_bank is not advanced.
- Read path:
  - The line RAM is synchronous-read; its address is the next position computed combinationally in the rgb_rdy cycle.
  - r/g/b are valid on the cycle after rgb_rdy and held stable until the next rgb_rdy.
  - A bank freed in cycle t is visible in in_ready at t+1.
- Colour expansion:
  - r = {r5, r5[4:2]}, g = {g6, g6[5:4]}, b = {b5, b5[4:2]}.
  - r/g/b are forced to 0 when line_ok=0.
- Underrun:
  - Set at an even-row decision where full[rd_bank]=0, except the row-pair containing row 0 after reset, which is black and not flagged.
  - If set and clear coincide, set wins.
- frame_start pulses the cycle after rgb_rdy consumes the last pixel of row OUT_H-1.
- Simultaneous events:
  - A write completing bank X and a read freeing bank Y in the same cycle both take effect.
  - A bank filled mid-row is not used until the next even-row decision.

Decomposition:
- Package dvi_scanline_pkg:
  - IN_W and OUT_H defaults.
  - RGB565 field offsets.
  - The expansion function for 5- and 6-bit channels to 8 bits.
- Sub-module dvi_line_ram: 2*IN_W x 16 simple dual-port RAM with synchronous read and read-enable (maps to iCE40 EBR).
  - Write address {wr_bank, wr_col}, read address {rd_bank, col_next}.

Test Plan:
- Reset checks:
  - Assert rst_pix mid-frame -> immediately r/g/b=0, in_ready=1, underrun=0.
  - After release, the first 640x2 pixels are black with underrun=0.
- Line replay:
  - Push 320 pixels, in_data=index.
  - Two rows of 640 rgb_rdy pulses (every 2nd cycle) -> each row shows pixel k on consumptions 2k and 2k+1, identical in both rows.
  - full[0] cleared the cycle after row 1 ends.
- Colour expansion:
  - 16'hF800 -> r=FF,g=00,b=00.
  - 16'h07E0 -> r=00,g=FF,b=00.
  - 16'h0841 -> r=08,g=08,b=08.
- Backpressure:
  - Push 640 pixels with no rgb_rdy -> in_ready=0 after the 640th accept.
  - Drive two rows -> in_ready=1 one cycle after the second row's last rgb_rdy.
- Underrun and resync:
  - No data at an even-row start -> 1280 black pixels and underrun=1 until clr_underrun.
  - A line completed mid-row appears only from the next even row.
  - in_sof on the 101st accepted pixel -> that pixel is stored at column 0.
- Frame wrap:
  - After 480 rows, frame_start=1 for exactly one cycle following the final rgb_rdy.
  - The next pixel is row 0, col 0.
